// File: rtl/fetch_unit_pkg.sv
// Pipeline constants and fetch state encoding shared by the fetch, decode and hazard units.
package fetch_unit_pkg;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake, ID-stage control and IF/ID outputs of the fetch stage.
interface fetch_unit_if;

  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        id_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] pc_add2;
  logic        wrt_IF_ID;
  logic        flush;
  logic        halted;

  modport master (
    output imem_rd, imem_addr, instr, pc_add2, wrt_IF_ID, flush, halted,
    input  imem_data, imem_done, id_stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_rd, imem_addr, instr, pc_add2, wrt_IF_ID, flush, halted,
    output imem_data, imem_done, id_stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// 16-bit program counter register with load enable and synchronous active-low reset.
module fetch_unit_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    pc_d = en ? d : pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign q = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and feeds the IF/ID register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = fetch_unit_pkg::RESET_PC,
  parameter logic [15:0] NOP_INSTR   = fetch_unit_pkg::NOP_INSTR,
  parameter logic [4:0]  HALT_OPCODE = fetch_unit_pkg::HALT_OPCODE
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic [15:0]  buf_q, buf_d;
  logic [15:0]  drain_addr_q, drain_addr_d;
  logic [15:0]  pc_q, pc_d, pc_inc;
  logic         pc_en;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == HALT_OPCODE;
  endfunction

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    drain_addr_d  = drain_addr_q;
    pc_en         = 1'b0;
    pc_d          = pc_inc;
    bus.imem_rd   = 1'b0;
    bus.imem_addr = pc_q;
    bus.instr     = NOP_INSTR;
    bus.pc_add2   = pc_inc;
    bus.wrt_IF_ID = 1'b0;
    bus.flush     = 1'b0;
    bus.halted    = 1'b0;

    if (bus.redirect) begin
      // A bubble always enters IF/ID; a request still in flight must be drained at its old address.
      bus.flush     = 1'b1;
      bus.wrt_IF_ID = 1'b1;
      pc_en         = 1'b1;
      pc_d          = bus.redirect_pc;
      buf_d         = NOP_INSTR;
      state_d       = FETCH;
      case (state_q)
        FETCH: begin
          bus.imem_rd = 1'b1;
          if (!bus.imem_done) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        DRAIN: begin
          bus.imem_rd   = 1'b1;
          bus.imem_addr = drain_addr_q;
          if (!bus.imem_done) state_d = DRAIN;
        end
        HALTED:  bus.halted = 1'b1;
        default: ;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          bus.imem_rd = 1'b1;
          if (bus.imem_done) begin
            if (!bus.id_stall) begin
              bus.instr     = bus.imem_data;
              bus.wrt_IF_ID = 1'b1;
              pc_en         = 1'b1;
              state_d       = is_halt(bus.imem_data) ? HALTED : FETCH;
            end else begin
              buf_d   = bus.imem_data;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          bus.instr     = buf_q;
          bus.wrt_IF_ID = !bus.id_stall;
          if (!bus.id_stall) begin
            pc_en   = 1'b1;
            state_d = is_halt(buf_q) ? HALTED : FETCH;
          end
        end
        DRAIN: begin
          bus.imem_rd   = 1'b1;
          bus.imem_addr = drain_addr_q;
          if (bus.imem_done) state_d = FETCH;
        end
        HALTED:  bus.halted = 1'b1;
        default: ;
      endcase
    end

    // Reset overrides every output so IF/ID sees a quiet stage while rst is low.
    if (!rst) begin
      bus.imem_rd   = 1'b0;
      bus.wrt_IF_ID = 1'b0;
      bus.flush     = 1'b0;
      bus.instr     = NOP_INSTR;
      bus.pc_add2   = 16'h0000;
      bus.halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      buf_q        <= NOP_INSTR;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle reference model plus hand-computed spot checks.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: where the PC is, whether a word is parked, whether a stale read is pending.
  logic [15:0] m_pc;
  logic [15:0] m_buf;
  logic        m_have;
  logic        m_stale;
  logic [15:0] m_stale_addr;
  logic        m_halt;

  initial begin
    m_pc = 16'h0000; m_buf = 16'h0800; m_have = 1'b0;
    m_stale = 1'b0; m_stale_addr = 16'h0000; m_halt = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk1("m_rst_rd", bus.imem_rd, 1'b0);
      chk1("m_rst_wrt", bus.wrt_IF_ID, 1'b0);
      chk1("m_rst_flush", bus.flush, 1'b0);
      chk1("m_rst_halted", bus.halted, 1'b0);
      chk("m_rst_instr", bus.instr, 16'h0800);
      chk("m_rst_pc_add2", bus.pc_add2, 16'h0000);
      m_pc = 16'h0000; m_have = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
    end else begin
      chk1("m_halted", bus.halted, m_halt);
      chk1("m_flush", bus.flush, bus.redirect);
      if (m_halt) begin
        chk1("m_halt_rd", bus.imem_rd, 1'b0);
        chk1("m_halt_wrt", bus.wrt_IF_ID, bus.redirect);
        if (bus.redirect) begin
          m_pc = bus.redirect_pc; m_halt = 1'b0;
        end
      end else if (m_stale) begin
        chk1("m_drain_rd", bus.imem_rd, 1'b1);
        chk("m_drain_addr", bus.imem_addr, m_stale_addr);
        chk1("m_drain_wrt", bus.wrt_IF_ID, bus.redirect);
        if (bus.redirect) m_pc = bus.redirect_pc;
        if (bus.imem_done) m_stale = 1'b0;
      end else if (m_have) begin
        chk1("m_hold_rd", bus.imem_rd, 1'b0);
        chk1("m_hold_wrt", bus.wrt_IF_ID, bus.redirect || !bus.id_stall);
        if (bus.redirect) begin
          m_pc = bus.redirect_pc; m_have = 1'b0;
        end else if (!bus.id_stall) begin
          chk("m_hold_instr", bus.instr, m_buf);
          chk("m_hold_pc_add2", bus.pc_add2, m_pc + 16'd2);
          m_halt = (m_buf[15:11] == 5'b00000);
          m_pc   = m_pc + 16'd2;
          m_have = 1'b0;
        end
      end else begin
        chk1("m_fetch_rd", bus.imem_rd, 1'b1);
        chk("m_fetch_addr", bus.imem_addr, m_pc);
        if (bus.redirect) begin
          chk1("m_redir_wrt", bus.wrt_IF_ID, 1'b1);
          if (!bus.imem_done) begin
            m_stale = 1'b1; m_stale_addr = m_pc;
          end
          m_pc = bus.redirect_pc;
        end else if (bus.imem_done && !bus.id_stall) begin
          chk1("m_deliver_wrt", bus.wrt_IF_ID, 1'b1);
          chk("m_deliver_instr", bus.instr, bus.imem_data);
          chk("m_deliver_pc_add2", bus.pc_add2, m_pc + 16'd2);
          m_halt = (bus.imem_data[15:11] == 5'b00000);
          m_pc   = m_pc + 16'd2;
        end else begin
          chk1("m_wait_wrt", bus.wrt_IF_ID, 1'b0);
          if (bus.imem_done) begin
            m_have = 1'b1; m_buf = bus.imem_data;
          end
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic r, input logic dn, input logic [15:0] dt,
                     input logic st, input logic rd, input logic [15:0] rp);
    rst = r;
    bus.imem_done   = dn;
    bus.imem_data   = dt;
    bus.id_stall    = st;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset, then a hit stream from 0
    drv(0, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk1("rst_rd", bus.imem_rd, 1'b0);
    chk1("rst_wrt", bus.wrt_IF_ID, 1'b0);
    chk("rst_instr", bus.instr, 16'h0800);
    nxt();
    drv(0, 0, 16'h0, 0, 0, 16'h0); @(negedge clk); nxt();
    drv(1, 1, 16'hC001, 0, 0, 16'h0); @(negedge clk);
    chk("hit0_addr", bus.imem_addr, 16'h0000);
    chk1("hit0_wrt", bus.wrt_IF_ID, 1'b1);
    chk("hit0_pc_add2", bus.pc_add2, 16'h0002);
    nxt();
    drv(1, 1, 16'hC002, 0, 0, 16'h0); @(negedge clk);
    chk("hit1_addr", bus.imem_addr, 16'h0002);
    chk("hit1_instr", bus.instr, 16'hC002);
    chk("hit1_pc_add2", bus.pc_add2, 16'h0004);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("hit2_addr", bus.imem_addr, 16'h0004);
    nxt();

    // Miss then stall on the returned word
    drv(0, 0, 16'h0, 0, 0, 16'h0); @(negedge clk); nxt();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
      chk1("miss_wrt", bus.wrt_IF_ID, 1'b0);
      nxt();
    end
    drv(1, 1, 16'hD123, 1, 0, 16'h0); @(negedge clk);
    chk1("stall_done_wrt", bus.wrt_IF_ID, 1'b0);
    nxt();
    drv(1, 0, 16'h0, 1, 0, 16'h0); @(negedge clk);
    chk1("hold_stall_wrt", bus.wrt_IF_ID, 1'b0);
    chk1("hold_rd", bus.imem_rd, 1'b0);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk1("hold_rel_wrt", bus.wrt_IF_ID, 1'b1);
    chk("hold_rel_instr", bus.instr, 16'hD123);
    chk("hold_rel_pc_add2", bus.pc_add2, 16'h0002);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk1("no_dup_wrt", bus.wrt_IF_ID, 1'b0);
    chk("after_hold_addr", bus.imem_addr, 16'h0002);
    nxt();

    // Redirect while the read of 0x0004 is outstanding
    drv(1, 1, 16'hC003, 0, 0, 16'h0); @(negedge clk); nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk); nxt();
    drv(1, 0, 16'h0, 0, 1, 16'h0040); @(negedge clk);
    chk1("redir_flush", bus.flush, 1'b1);
    chk1("redir_wrt", bus.wrt_IF_ID, 1'b1);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("drain_addr", bus.imem_addr, 16'h0004);
    chk1("drain_wrt", bus.wrt_IF_ID, 1'b0);
    nxt();
    drv(1, 1, 16'hBEEF, 0, 0, 16'h0); @(negedge clk);
    chk1("drain_done_wrt", bus.wrt_IF_ID, 1'b0);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("post_drain_addr", bus.imem_addr, 16'h0040);
    nxt();
    drv(1, 1, 16'hC040, 0, 0, 16'h0); @(negedge clk);
    chk("tgt_pc_add2", bus.pc_add2, 16'h0042);
    nxt();

    // Redirect coincident with done under stall, then redirect while holding
    drv(1, 1, 16'h1111, 1, 1, 16'h0080); @(negedge clk);
    chk1("coinc_flush", bus.flush, 1'b1);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("coinc_next_addr", bus.imem_addr, 16'h0080);
    nxt();
    drv(1, 1, 16'h2222, 1, 0, 16'h0); @(negedge clk); nxt();
    drv(1, 0, 16'h0, 1, 1, 16'h0090); @(negedge clk);
    chk1("hold_redir_wrt", bus.wrt_IF_ID, 1'b1);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("hold_redir_addr", bus.imem_addr, 16'h0090);
    nxt();
    drv(1, 1, 16'hC090, 0, 0, 16'h0); @(negedge clk);
    chk("hold_redir_instr", bus.instr, 16'hC090);
    nxt();

    // HALT at 0x0010, resume by redirect to 0x0020
    drv(1, 1, 16'h5555, 0, 1, 16'h0010); @(negedge clk); nxt();
    drv(1, 1, 16'h0000, 0, 0, 16'h0); @(negedge clk);
    chk("halt_addr", bus.imem_addr, 16'h0010);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk1("halted_set", bus.halted, 1'b1);
    chk1("halted_rd", bus.imem_rd, 1'b0);
    nxt();
    drv(1, 1, 16'hC0DE, 0, 0, 16'h0); @(negedge clk);
    chk1("halted_wrt", bus.wrt_IF_ID, 1'b0);
    nxt();
    drv(1, 0, 16'h0, 0, 1, 16'h0020); @(negedge clk); nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk1("resume_halted", bus.halted, 1'b0);
    chk("resume_addr", bus.imem_addr, 16'h0020);
    nxt();

    // PC wrap at 0xFFFE
    drv(1, 1, 16'h5555, 0, 1, 16'hFFFE); @(negedge clk); nxt();
    drv(1, 1, 16'hC0FF, 0, 0, 16'h0); @(negedge clk);
    chk("wrap_pc_add2", bus.pc_add2, 16'h0000);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    nxt();

    // Reset while draining, with a redirect asserted under reset
    drv(1, 0, 16'h0, 0, 1, 16'h0300); @(negedge clk); nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk); nxt();
    drv(0, 1, 16'hAAAA, 0, 1, 16'h0500); @(negedge clk);
    chk1("rst_drain_flush", bus.flush, 1'b0);
    chk1("rst_drain_rd", bus.imem_rd, 1'b0);
    nxt();
    drv(1, 0, 16'h0, 0, 0, 16'h0); @(negedge clk);
    chk("rst_drain_addr", bus.imem_addr, 16'h0000);
    chk1("rst_drain_fetch", bus.imem_rd, 1'b1);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
